// File: rtl/vga_plot_arbiter.sv
// Round-robin owner of the single VGA plot port, shared by NREQ drawing engines via start/done.
// Latency: req->eng_start 1 cycle, done->ack 1 cycle; pixel path is combinational (zero latency).
// Backpressure: one grant at a time; others wait in req; a watchdog revokes grants held TIMEOUT cycles.
module vga_plot_arbiter #(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 32768
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    output logic [NREQ-1:0]     ack,
    output logic [NREQ-1:0]     timeout,
    output logic                busy,
    output logic [2:0]          grant_id,
    output logic [NREQ-1:0]     eng_start,
    input  logic [NREQ-1:0]     eng_done,
    input  logic [8*NREQ-1:0]   eng_x,
    input  logic [7*NREQ-1:0]   eng_y,
    input  logic [3*NREQ-1:0]   eng_colour,
    input  logic [NREQ-1:0]     eng_plot,
    output logic [7:0]          vga_x,
    output logic [6:0]          vga_y,
    output logic [2:0]          vga_colour,
    output logic                vga_plot
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_TOP = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t          state, state_nxt;
    logic [2:0]      ptr, ptr_nxt, gid_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [NREQ-1:0] ack_nxt, to_nxt;
    logic [NREQ-1:0] gid_onehot;
    logic            sel_done, sel_plot;
    logic [7:0]      sel_x;
    logic [6:0]      sel_y;
    logic [2:0]      sel_colour;
    logic [3:0]      pick;

    // First set request bit scanning ptr, ptr+1, ... wrapping; returns {found, index}.
    function automatic logic [3:0] rr_pick(input logic [NREQ-1:0] r, input logic [2:0] p);
        logic [3:0] res;
        int         idx;
        res = '0;
        // Scan from the farthest offset down so the nearest offset to ptr is written last.
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(p) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (r[idx]) res = {1'b1, idx[2:0]};
        end
        return res;
    endfunction

    // Select the granted engine's signals without a variable-width index into the buses.
    always_comb begin
        gid_onehot = '0;
        sel_done   = 1'b0;
        sel_plot   = 1'b0;
        sel_x      = '0;
        sel_y      = '0;
        sel_colour = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == 3'(i)) begin
                gid_onehot[i] = 1'b1;
                sel_done      = eng_done[i];
                sel_plot      = eng_plot[i];
                sel_x         = eng_x[8*i +: 8];
                sel_y         = eng_y[7*i +: 7];
                sel_colour    = eng_colour[3*i +: 3];
            end
        end
    end

    // Next-state logic: arbitration in IDLE, done/watchdog in GRANT, pointer advance in RELEASE.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        gid_nxt   = grant_id;
        ack_nxt   = '0;
        to_nxt    = '0;
        pick      = rr_pick(req, ptr);
        case (state)
            IDLE: begin
                if (pick[3]) begin
                    gid_nxt   = pick[2:0];
                    cnt_nxt   = '0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                // Done takes priority over a watchdog expiry landing in the same cycle.
                if (sel_done) begin
                    ack_nxt   = gid_onehot;
                    cnt_nxt   = '0;
                    state_nxt = RELEASE;
                end else if (cnt == CNT_TOP) begin
                    ack_nxt   = gid_onehot;
                    to_nxt    = gid_onehot;
                    cnt_nxt   = '0;
                    state_nxt = RELEASE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RELEASE: begin
                ptr_nxt   = (grant_id == 3'(NREQ - 1)) ? 3'd0 : grant_id + 3'd1;
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; ack/timeout are registered so they are clean one-cycle pulses in RELEASE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            cnt      <= '0;
            grant_id <= '0;
            ack      <= '0;
            timeout  <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            cnt      <= cnt_nxt;
            grant_id <= gid_nxt;
            ack      <= ack_nxt;
            timeout  <= to_nxt;
        end
    end

    // Start and pixel path are live only in GRANT; RELEASE drops start so the engine clears done.
    always_comb begin
        busy       = (state != IDLE);
        eng_start  = (state == GRANT) ? gid_onehot : '0;
        vga_plot   = (state == GRANT) && sel_plot;
        vga_x      = (state == GRANT) ? sel_x      : '0;
        vga_y      = (state == GRANT) ? sel_y      : '0;
        vga_colour = (state == GRANT) ? sel_colour : '0;
    end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter: vector table for reset and round-robin,
// hand-written sequences for watchdog, done-vs-timeout and reset mid-grant.
// Inputs change on the falling edge; outputs are compared 1 time unit later.
module tb_vga_plot_arbiter;

    localparam int NREQ = 3;
    localparam int TO   = 16;

    logic             clk;
    logic             rst;
    logic [NREQ-1:0]  req, ack, timeout, eng_start, eng_done, eng_plot;
    logic             busy, vga_plot;
    logic [2:0]       grant_id, vga_colour;
    logic [8*NREQ-1:0] eng_x;
    logic [7*NREQ-1:0] eng_y;
    logic [3*NREQ-1:0] eng_colour;
    logic [7:0]       vga_x;
    logic [6:0]       vga_y;

    int pass_cnt = 0;
    int total    = 0;
    int rowno    = 0;

    typedef struct {
        logic       rs;
        logic [2:0] rq;
        logic [2:0] dn;
        logic [2:0] pl;
        logic [2:0] st;
        logic [2:0] ak;
        logic [2:0] to;
        logic       bz;
        logic [2:0] gid;
        logic       vp;
        logic       gr;
    } row_t;

    row_t tbl[$];

    vga_plot_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .ack(ack), .timeout(timeout),
        .busy(busy), .grant_id(grant_id), .eng_start(eng_start),
        .eng_done(eng_done), .eng_x(eng_x), .eng_y(eng_y),
        .eng_colour(eng_colour), .eng_plot(eng_plot),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] exp_x(input logic [2:0] g);
        case (g)
            3'd0: return 8'd11;
            3'd1: return 8'd37;
            default: return 8'd200;
        endcase
    endfunction

    function automatic logic [6:0] exp_y(input logic [2:0] g);
        case (g)
            3'd0: return 7'd21;
            3'd1: return 7'd99;
            default: return 7'd120;
        endcase
    endfunction

    function automatic logic [2:0] exp_c(input logic [2:0] g);
        case (g)
            3'd0: return 3'd1;
            3'd1: return 3'd5;
            default: return 3'd6;
        endcase
    endfunction

    function automatic row_t mk(input logic rs, input logic [2:0] rq, input logic [2:0] dn,
                                input logic [2:0] pl, input logic [2:0] st, input logic [2:0] ak,
                                input logic [2:0] to, input logic bz, input logic [2:0] gid,
                                input logic vp, input logic gr);
        row_t r;
        r.rs = rs; r.rq = rq; r.dn = dn; r.pl = pl; r.st = st; r.ak = ak;
        r.to = to; r.bz = bz; r.gid = gid; r.vp = vp; r.gr = gr;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    task automatic apply_row(input row_t r);
        logic [7:0] ex;
        logic [6:0] ey;
        logic [2:0] ec;
        @(negedge clk);
        rst      = r.rs;
        req      = r.rq;
        eng_done = r.dn;
        eng_plot = r.pl;
        #1;
        ex = r.gr ? exp_x(r.gid) : 8'd0;
        ey = r.gr ? exp_y(r.gid) : 7'd0;
        ec = r.gr ? exp_c(r.gid) : 3'd0;
        chk($sformatf("r%0d eng_start", rowno), 32'(eng_start), 32'(r.st));
        chk($sformatf("r%0d ack", rowno), 32'(ack), 32'(r.ak));
        chk($sformatf("r%0d timeout", rowno), 32'(timeout), 32'(r.to));
        chk($sformatf("r%0d busy", rowno), 32'(busy), 32'(r.bz));
        chk($sformatf("r%0d grant_id", rowno), 32'(grant_id), 32'(r.gid));
        chk($sformatf("r%0d vga_plot", rowno), 32'(vga_plot), 32'(r.vp));
        chk($sformatf("r%0d vga_x", rowno), 32'(vga_x), 32'(ex));
        chk($sformatf("r%0d vga_y", rowno), 32'(vga_y), 32'(ey));
        chk($sformatf("r%0d vga_colour", rowno), 32'(vga_colour), 32'(ec));
        rowno++;
    endtask

    initial begin
        logic [2:0] order[4];
        logic [2:0] g, oh, dn, pl, rq;
        logic       vp;

        rst        = 1'b1;
        req        = 3'b111;
        eng_done   = '0;
        eng_plot   = 3'b111;
        eng_x      = {8'd200, 8'd37, 8'd11};
        eng_y      = {7'd120, 7'd99, 7'd21};
        eng_colour = {3'd6, 3'd5, 3'd1};

        // Vector table: reset, then four jobs in round-robin order, each done 5 cycles after start.
        tbl.push_back(mk(1, 3'b111, 0, 3'b111, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 3'b111, 0, 3'b111, 0, 0, 0, 0, 0, 0, 0));
        order[0] = 3'd0; order[1] = 3'd1; order[2] = 3'd2; order[3] = 3'd0;
        for (int j = 0; j < 4; j++) begin
            g  = order[j];
            oh = 3'b001 << g;
            for (int k = 0; k < 6; k++) begin
                dn = (k == 5) ? oh : 3'b000;
                // One cycle where only ungranted engines strobe plot: nothing may reach the adapter.
                pl = (k == 2) ? ~oh : 3'b111;
                vp = (k == 2) ? 1'b0 : 1'b1;
                tbl.push_back(mk(0, 3'b111, dn, pl, oh, 0, 0, 1, g, vp, 1));
            end
            tbl.push_back(mk(0, 3'b111, 0, 3'b111, 0, oh, 0, 1, g, 0, 0));
            rq = (j == 3) ? 3'b000 : 3'b111;
            tbl.push_back(mk(0, rq, 0, 3'b111, 0, 0, 0, 0, g, 0, 0));
        end

        repeat (2) @(posedge clk);
        foreach (tbl[i]) apply_row(tbl[i]);

        // Watchdog: engine 2 never finishes; exactly 16 GRANT cycles, then ack+timeout.
        apply_row(mk(0, 3'b100, 0, 3'b111, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < TO; k++)
            apply_row(mk(0, 3'b100, 0, 3'b111, 3'b100, 0, 0, 1, 2, 1, 1));
        apply_row(mk(0, 3'b011, 0, 3'b111, 0, 3'b100, 3'b100, 1, 2, 0, 0));
        apply_row(mk(0, 3'b011, 0, 3'b111, 0, 0, 0, 0, 2, 0, 0));

        // Done on the final counter cycle wins; req drop mid-grant does not revoke.
        apply_row(mk(0, 3'b011, 0, 3'b111, 3'b001, 0, 0, 1, 0, 1, 1));
        for (int k = 1; k < TO - 1; k++)
            apply_row(mk(0, 3'b000, 0, 3'b111, 3'b001, 0, 0, 1, 0, 1, 1));
        apply_row(mk(0, 3'b000, 3'b001, 3'b111, 3'b001, 0, 0, 1, 0, 1, 1));
        apply_row(mk(0, 3'b000, 0, 3'b111, 0, 3'b001, 0, 1, 0, 0, 0));
        apply_row(mk(0, 3'b001, 0, 3'b111, 0, 0, 0, 0, 0, 0, 0));

        // Reset mid-grant: start drops with no ack, then engine 0 is regranted.
        apply_row(mk(0, 3'b001, 0, 3'b111, 3'b001, 0, 0, 1, 0, 1, 1));
        apply_row(mk(1, 3'b001, 0, 3'b111, 3'b001, 0, 0, 1, 0, 1, 1));
        apply_row(mk(0, 3'b001, 0, 3'b111, 0, 0, 0, 0, 0, 0, 0));
        apply_row(mk(0, 3'b001, 0, 3'b111, 3'b001, 0, 0, 1, 0, 1, 1));
        apply_row(mk(0, 3'b000, 3'b001, 3'b111, 3'b001, 0, 0, 1, 0, 1, 1));
        apply_row(mk(0, 3'b000, 0, 3'b111, 0, 3'b001, 0, 1, 0, 0, 0));

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
